// File: rtl/muldiv_unit_pkg.sv
// Shared op codes for the multiply/divide unit.
// The values match the muldiv op field decoded in ID.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    mdMult  = 3'd0,
    mdMultu = 3'd1,
    mdDiv   = 3'd2,
    mdDivu  = 3'd3,
    mdMthi  = 3'd4,
    mdMtlo  = 3'd5
  } mdOp_t;

endpackage

// File: rtl/muldiv_unit_divstep.sv
// One restoring-division iteration.
// Shifts the next dividend bit into the partial remainder and subtracts the divisor when it fits.
module restoring_divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] quotNext
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // The difference only fits in WIDTH bits when fits is set, which is the only time it is used
  always_comb begin
    shifted  = {rem, quot[WIDTH-1]};
    fits     = shifted >= {1'b0, divisor};
    diff     = shifted[WIDTH-1:0] - divisor;
    remNext  = fits ? diff : shifted[WIDTH-1:0];
    quotNext = {quot[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// busy covers every cycle of an in-flight op so the hazard unit can stall dependents.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DIV_CYCLES = WIDTH + 1;
  localparam int CW         = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state, stateNext;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mulA, mulB, rem, quot, divisor;
  logic             mulSigned, qNeg, rNeg, divZero;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] remNext, quotNext, magA, magB, qFix, rFix;
  logic             divSigned, accept;

  restoring_divider_step #(.WIDTH(WIDTH)) divStep (
    .rem      (rem),
    .quot     (quot),
    .divisor  (divisor),
    .remNext  (remNext),
    .quotNext (quotNext)
  );

  always_comb begin
    accept    = (state == IDLE) && start && !flush;
    divSigned = (op == mdDiv);
    magA      = (divSigned && A[WIDTH-1]) ? -A : A;
    magB      = (divSigned && B[WIDTH-1]) ? -B : B;
    qFix      = qNeg ? -quot : quot;
    rFix      = rNeg ? -rem : rem;
    if (mulSigned)
      prod = $signed({{WIDTH{mulA[WIDTH-1]}}, mulA}) * $signed({{WIDTH{mulB[WIDTH-1]}}, mulB});
    else
      prod = {{WIDTH{1'b0}}, mulA} * {{WIDTH{1'b0}}, mulB};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Flush only matters once busy; an IDLE flush merely suppresses a same-cycle start
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) begin
        case (op)
          mdMult, mdMultu: stateNext = MUL;
          mdDiv, mdDivu:   stateNext = DIV;
          default:         stateNext = IDLE;
        endcase
      end
      MUL:     if (flush || count == CW'(1)) stateNext = IDLE;
      DIV:     if (flush) stateNext = IDLE;
               else if (count == CW'(2)) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0; lo <= '0; count <= '0;
      mulA <= '0; mulB <= '0; mulSigned <= 1'b0;
      rem <= '0; quot <= '0; divisor <= '0;
      qNeg <= 1'b0; rNeg <= 1'b0; divZero <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        case (op)
          mdMthi: hi <= A;
          mdMtlo: lo <= A;
          mdMult, mdMultu: begin
            mulA      <= A;
            mulB      <= B;
            mulSigned <= (op == mdMult);
            count     <= CW'(MUL_CYCLES);
          end
          mdDiv, mdDivu: begin
            quot    <= magA;
            rem     <= '0;
            divisor <= magB;
            qNeg    <= divSigned && (A[WIDTH-1] ^ B[WIDTH-1]);
            rNeg    <= divSigned && A[WIDTH-1];
            divZero <= (B == '0);
            count   <= CW'(DIV_CYCLES);
          end
          default: ;
        endcase
      end
    end else if (!flush) begin
      count <= count - CW'(1);
      case (state)
        MUL: if (count == CW'(1)) {hi, lo} <= prod;
        DIV: begin
          rem  <= remNext;
          quot <= quotNext;
        end
        FIX: begin
          hi <= rFix;
          lo <= divZero ? '1 : qFix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed HI/LO results and busy lengths.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  int n;

  muldiv_unit #(.WIDTH(32), .MUL_CYCLES(5)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one op for a single edge; on return the bench sits in the first cycle after that edge
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    step();
    start = 1'b0;
  endtask

  task automatic runToDone(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      step();
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int expCycles, input logic [31:0] expHi, input logic [31:0] expLo);
    int c;
    applyStimulus(o, a, b);
    runToDone(c);
    checkOutput({tag, " cycles"}, 64'(c), 64'(expCycles));
    checkOutput({tag, " hi"}, {32'd0, hi}, {32'd0, expHi});
    checkOutput({tag, " lo"}, {32'd0, lo}, {32'd0, expLo});
  endtask

  initial begin
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset hi", {32'd0, hi}, 64'd0);
    checkOutput("reset lo", {32'd0, lo}, 64'd0);

    runOp("multu", mdMultu, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    runOp("mult", mdMult, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    runOp("div neg", mdDiv, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("div negdivisor", mdDiv, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
    runOp("divu big", mdDivu, 32'hFFFF_FFFF, 32'd3, 33, 32'd0, 32'h5555_5555);
    runOp("divu by0", mdDivu, 32'd100, 32'd0, 33, 32'd100, 32'hFFFF_FFFF);
    runOp("div by0", mdDiv, 32'hFFFF_FFFB, 32'd0, 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    runOp("div ovf", mdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);

    applyStimulus(mdMtlo, 32'h1234, 32'd0);
    checkOutput("mtlo busy", {63'd0, busy}, 64'd0);
    checkOutput("mtlo lo", {32'd0, lo}, 64'h1234);

    // Second start lands in busy cycle 3 and must be dropped
    applyStimulus(mdDivu, 32'd9, 32'd4);
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == 2) checkOutput("hold lo", {32'd0, lo}, 64'h1234);
      if (n == 3) begin
        start = 1'b1; op = mdMultu; A = 32'd5; B = 32'd5;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    checkOutput("divu2 cycles", 64'(n), 64'd33);
    checkOutput("divu2 hi", {32'd0, hi}, 64'd1);
    checkOutput("divu2 lo", {32'd0, lo}, 64'd2);
    step();
    checkOutput("ignored start busy", {63'd0, busy}, 64'd0);

    applyStimulus(mdMthi, 32'hAA, 32'd0);
    applyStimulus(mdMultu, 32'd3, 32'd3);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush busy", {63'd0, busy}, 64'd0);
    checkOutput("flush hi", {32'd0, hi}, 64'hAA);
    checkOutput("flush lo", {32'd0, lo}, 64'd2);
    for (int i = 0; i < 6; i++) step();
    checkOutput("flush late lo", {32'd0, lo}, 64'd2);

    flush = 1'b1;
    applyStimulus(mdMtlo, 32'h55, 32'd0);
    flush = 1'b0;
    checkOutput("idle flush lo", {32'd0, lo}, 64'd2);

    applyStimulus(mdMthi, 32'hAA, 32'd0);
    applyStimulus(mdMultu, 32'd3, 32'd3);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rst busy", {63'd0, busy}, 64'd0);
    checkOutput("rst hi", {32'd0, hi}, 64'd0);
    checkOutput("rst lo", {32'd0, lo}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
